// File: rtl/vram_scanout_if.sv
// Signal bundle between vram_scanout, the video RAM read port and the VGA pins.
// The master drives the RAM address and video outputs. The slave returns vram_data one cycle after vram_addr.
interface vram_scanout_if;
  logic [13:0] vram_addr;
  logic [7:0]  vram_data;
  logic        hs;
  logic        vs;
  logic        de;
  logic        frame_start;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  modport master (
    output vram_addr, hs, vs, de, frame_start, r, g, b,
    input  vram_data
  );

  modport slave (
    input  vram_addr, hs, vs, de, frame_start, r, g, b,
    output vram_data
  );
endinterface

// File: rtl/vram_scanout.sv
// 640x480@60 VGA scanout of a 160x100 RGB332 framebuffer (4x4 pixel blocks, 40-line borders).
// Optional macro SCANOUT_SCANLINES_EN halves every channel on odd picture lines.
module vram_scanout (
  input  logic           pixel_clock,
  input  logic           reset,
  vram_scanout_if.master bus
);
  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_VIS       = 10'd640;
  localparam logic [9:0] HS_FIRST    = 10'd656;
  localparam logic [9:0] HS_LAST     = 10'd751;
  localparam logic [9:0] V_LAST      = 10'd524;
  localparam logic [9:0] V_VIS       = 10'd480;
  localparam logic [9:0] V_PIC_FIRST = 10'd40;
  localparam logic [9:0] V_PIC_END   = 10'd440;
  localparam logic [9:0] VS_FIRST    = 10'd490;
  localparam logic [9:0] VS_LAST     = 10'd491;

  // Flag vector layout: {pic, dim, de, hs, vs, frame_start}; syncs idle high.
  localparam int         F_PIC     = 5;
  localparam int         F_DIM     = 4;
  localparam int         F_DE      = 3;
  localparam int         F_HS      = 2;
  localparam int         F_VS      = 1;
  localparam int         F_FS      = 0;
  localparam logic [5:0] FLAGS_RST = 6'b000110;

  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic [5:0]  r_s1;
  logic [5:0]  r_s2;
  logic [13:0] r_vram_addr;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_fs;
  logic [7:0]  r_r;
  logic [7:0]  r_g;
  logic [7:0]  r_b;

  logic        w_pic;
  logic        w_dim;
  logic [5:0]  w_flags;
  logic [9:0]  w_vrel;
  logic [6:0]  w_row;
  logic [7:0]  w_col;
  logic [13:0] w_addr;
  logic        w_unused;
  logic [7:0]  w_d;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [7:0]  w_b;

  // Stage 0: raster counters
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

  assign w_pic  = (r_hcnt < H_VIS) && (r_vcnt >= V_PIC_FIRST) && (r_vcnt < V_PIC_END);
  assign w_vrel = r_vcnt - V_PIC_FIRST;
  assign w_row  = w_vrel[8:2];
  assign w_col  = r_hcnt[9:2];
  // row*160 as two shifts; the largest address is 15999, so 14 bits never overflow
  assign w_addr = {w_row, 7'b0} + {2'b0, w_row, 5'b0} + {6'b0, w_col};
  assign w_unused = ^{w_vrel[9], w_vrel[1:0]};

`ifdef SCANOUT_SCANLINES_EN
  assign w_dim = w_pic & r_vcnt[0];
`else
  assign w_dim = 1'b0;
`endif

  assign w_flags = {w_pic,
                    w_dim,
                    (r_hcnt < H_VIS) && (r_vcnt < V_VIS),
                    !((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST)),
                    !((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST)),
                    (r_hcnt == 10'd0) && (r_vcnt == 10'd0)};

  // Stages 1 and 2: address register plus flag delay line matching the RAM latency
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_vram_addr <= '0;
      r_s1        <= FLAGS_RST;
      r_s2        <= FLAGS_RST;
    end else begin
      r_vram_addr <= w_pic ? w_addr : 14'd0;
      r_s1        <= w_flags;
      r_s2        <= r_s1;
    end
  end

  // RGB332 expansion by bit replication; borders and blanking are forced black
  always_comb begin
    w_d = bus.vram_data;
    w_r = {w_d[7:5], w_d[7:5], w_d[7:6]};
    w_g = {w_d[4:2], w_d[4:2], w_d[4:3]};
    w_b = {w_d[1:0], w_d[1:0], w_d[1:0], w_d[1:0]};
    if (!r_s2[F_PIC]) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end else if (r_s2[F_DIM]) begin
      w_r = {1'b0, w_r[7:1]};
      w_g = {1'b0, w_g[7:1]};
      w_b = {1'b0, w_b[7:1]};
    end
  end

  // Stage 3: output registers
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_de <= 1'b0;
      r_fs <= 1'b0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_hs <= r_s2[F_HS];
      r_vs <= r_s2[F_VS];
      r_de <= r_s2[F_DE];
      r_fs <= r_s2[F_FS];
      r_r  <= w_r;
      r_g  <= w_g;
      r_b  <= w_b;
    end
  end

  assign bus.vram_addr   = r_vram_addr;
  assign bus.hs          = r_hs;
  assign bus.vs          = r_vs;
  assign bus.de          = r_de;
  assign bus.frame_start = r_fs;
  assign bus.r           = r_r;
  assign bus.g           = r_g;
  assign bus.b           = r_b;
endmodule

// File: tb/tb_vram_scanout.sv
// Testbench for vram_scanout: raster model feeding expected-output queues, plus fixed-point checks.
module tb_vram_scanout;
  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_scanout_if bus ();

  vram_scanout dut (
    .pixel_clock (clk),
    .reset       (rst),
    .bus         (bus)
  );

  // synchronous video RAM: data one cycle after the address
  logic [7:0] mem [0:16383];
  always @(posedge clk) bus.vram_data <= mem[bus.vram_addr];

  localparam logic [27:0] RST_VID = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic [27:0] exp_q [$];
  logic [13:0] addr_q [$];
  int m_h, m_v, n_tick;
  int checks = 0;
  int failures = 0;

  logic [27:0] w_vid;
  assign w_vid = {bus.hs, bus.vs, bus.de, bus.frame_start, bus.r, bus.g, bus.b};

  function automatic logic [13:0] exp_addr(int h, int v);
    if (h < 640 && v >= 40 && v < 440) return 14'(((v - 40) / 4) * 160 + h / 4);
    return 14'd0;
  endfunction

  function automatic logic [27:0] model_out(int h, int v);
    logic       pic;
    logic [7:0] d, cr, cg, cb;
    pic = (h < 640 && v >= 40 && v < 440);
    d   = mem[exp_addr(h, v)];
    cr  = {d[7:5], d[7:5], d[7:6]};
    cg  = {d[4:2], d[4:2], d[4:3]};
    cb  = {d[1:0], d[1:0], d[1:0], d[1:0]};
    if (!pic) begin
      cr = 8'h00; cg = 8'h00; cb = 8'h00;
    end
`ifdef SCANOUT_SCANLINES_EN
    if (pic && (v % 2 == 1)) begin
      cr = cr >> 1; cg = cg >> 1; cb = cb >> 1;
    end
`endif
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491),
            (h < 640 && v < 480), (h == 0 && v == 0), cr, cg, cb};
  endfunction

  // driver: one clock edge; pushes expectations for the counter state entering the pipeline
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      repeat (3) exp_q.push_back(RST_VID);
      addr_q.push_back(14'd0);
      m_h = 0; m_v = 0; n_tick = 0;
    end else begin
      void'(exp_q.pop_front());
      void'(addr_q.pop_front());
      exp_q.push_back(model_out(m_h, m_v));
      addr_q.push_back(exp_addr(m_h, m_v));
      if (m_h == 799) begin
        m_h = 0;
        m_v = (m_v == 524) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      n_tick = n_tick + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (w_vid !== RST_VID) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d act=%h exp=%h", k, w_vid, RST_VID);
      end
      checks++;
      if (bus.vram_addr !== 14'd0) begin
        failures++;
        $display("FAIL reset_addr cycle=%0d act=%0d exp=0", k, bus.vram_addr);
      end
    end
  endtask

  task automatic test_startup(string tag);
    logic [1:0] want;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k == 3) ? 2'b11 : (k == 4) ? 2'b10 : 2'b00;
      checks++;
      if ({bus.de, bus.frame_start} !== want) begin
        failures++;
        $display("FAIL %s_de_fs k=%0d act=%b exp=%b", tag, k, {bus.de, bus.frame_start}, want);
      end
      checks++;
      if (w_vid !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_vid k=%0d act=%h exp=%h", tag, k, w_vid, exp_q[0]);
      end
      checks++;
      if (bus.vram_addr !== addr_q[0]) begin
        failures++;
        $display("FAIL %s_addr k=%0d act=%0d exp=%0d", tag, k, bus.vram_addr, addr_q[0]);
      end
    end
  endtask

  // lines 0..39: scoreboard every cycle, plus hs/de counts and black border
  task automatic test_border(string tag);
    int hs_low = 0, de_high = 0, fs_cnt = 0, lit_border = 0, bad_addr = 0;
    for (int i = 0; i < 40 * 800; i++) begin
      tick();
      if (!bus.hs) hs_low++;
      if (bus.de) de_high++;
      if (bus.frame_start) fs_cnt++;
      if (bus.de && (n_tick - 3) < 32000 && w_vid[23:0] != 24'h0) lit_border++;
      if ((n_tick - 1) < 32000 && bus.vram_addr != 14'd0) bad_addr++;
      checks++;
      if (w_vid !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_vid t=%0d act=%h exp=%h", tag, n_tick, w_vid, exp_q[0]);
      end
      checks++;
      if (bus.vram_addr !== addr_q[0]) begin
        failures++;
        $display("FAIL %s_addr t=%0d act=%0d exp=%0d", tag, n_tick, bus.vram_addr, addr_q[0]);
      end
    end
    checks++;
    if (hs_low !== 40 * 96) begin
      failures++;
      $display("FAIL %s_hs_low_count act=%0d exp=%0d", tag, hs_low, 40 * 96);
    end
    checks++;
    if (de_high !== 40 * 640) begin
      failures++;
      $display("FAIL %s_de_count act=%0d exp=%0d", tag, de_high, 40 * 640);
    end
    checks++;
    if (fs_cnt !== 0) begin
      failures++;
      $display("FAIL %s_extra_frame_start act=%0d exp=0", tag, fs_cnt);
    end
    checks++;
    if (lit_border !== 0) begin
      failures++;
      $display("FAIL %s_border_black act=%0d exp=0", tag, lit_border);
    end
    checks++;
    if (bad_addr !== 0) begin
      failures++;
      $display("FAIL %s_border_addr act=%0d exp=0", tag, bad_addr);
    end
  endtask

  // lines 40..45: address replication, colour expansion, data pattern
  task automatic test_picture();
    int          a_idx [9];
    logic [13:0] a_exp [9];
    int          c_idx [11];
    logic [24:0] c_exp [11];
    a_idx = '{32000, 32003, 32004, 32639, 32640, 32805, 35039, 35200, 35839};
    a_exp = '{14'd0, 14'd0, 14'd1, 14'd159, 14'd0, 14'd1, 14'd159, 14'd160, 14'd319};
    c_idx = '{32000, 32003, 32004, 32007, 32008, 32011, 32012, 32015, 32800, 35240, 32640};
    c_exp = '{25'h1FF0000, 25'h1FF0000, 25'h100FF00, 25'h100FF00, 25'h10000FF, 25'h10000FF,
              25'h1FFFFFF, 25'h1FFFFFF, 25'h1FF0000, 25'h1B649AA, 25'h0000000};
`ifdef SCANOUT_SCANLINES_EN
    c_exp[8] = 25'h17F0000;
`endif
    for (int i = 0; i < 6 * 800; i++) begin
      tick();
      checks++;
      if (w_vid !== exp_q[0]) begin
        failures++;
        $display("FAIL picture_vid t=%0d act=%h exp=%h", n_tick, w_vid, exp_q[0]);
      end
      checks++;
      if (bus.vram_addr !== addr_q[0]) begin
        failures++;
        $display("FAIL picture_addr t=%0d act=%0d exp=%0d", n_tick, bus.vram_addr, addr_q[0]);
      end
      for (int k = 0; k < 9; k++) begin
        if ((n_tick - 1) == a_idx[k]) begin
          checks++;
          if (bus.vram_addr !== a_exp[k]) begin
            failures++;
            $display("FAIL addr_point idx=%0d act=%0d exp=%0d", a_idx[k], bus.vram_addr, a_exp[k]);
          end
        end
      end
      for (int k = 0; k < 11; k++) begin
        if ((n_tick - 3) == c_idx[k]) begin
          checks++;
          if ({bus.de, bus.r, bus.g, bus.b} !== c_exp[k]) begin
            failures++;
            $display("FAIL colour_point idx=%0d act=%h exp=%h", c_idx[k],
                     {bus.de, bus.r, bus.g, bus.b}, c_exp[k]);
          end
        end
      end
    end
  endtask

  // one-cycle reset mid-line, then the restart must look exactly like power-up
  task automatic test_mid_reset();
    int guard = 0;
    while (m_h != 300 && guard < 800) begin
      tick();
      guard++;
      checks++;
      if (w_vid !== exp_q[0]) begin
        failures++;
        $display("FAIL pre_reset_vid t=%0d act=%h exp=%h", n_tick, w_vid, exp_q[0]);
      end
    end
    checks++;
    if (m_h != 300) begin
      failures++;
      $display("FAIL mid_reset_position act=%0d exp=300", m_h);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (w_vid !== RST_VID) begin
      failures++;
      $display("FAIL mid_reset_outputs act=%h exp=%h", w_vid, RST_VID);
    end
    checks++;
    if (bus.vram_addr !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset_addr act=%0d exp=0", bus.vram_addr);
    end
    test_startup("restart");
    test_border("restart");
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = i[7:0];
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    mem[2] = 8'h03;
    mem[3] = 8'hFF;
    test_reset();
    test_startup("startup");
    test_border("border");
    test_picture();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
